ei_axi4_rd_arbiter: RTL and testbench

- Read-path arbiter that shares one AXI4 read interface (AR + R channels) between NUM_M requesters inside the AXI4 VIP environment.
- Arbitrates AR requests round-robin and tags ARID with the requester index. Routes R beats back to the requester by that tag.
- Limits outstanding bursts per requester so no single requester can starve the shared slave.
- Sits between the VIP master-side agents and the single slave-facing interface.

---
 rtl/ei_axi4_rd_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_ei_axi4_rd_arbiter.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ei_axi4_rd_arbiter.sv
// ei_axi4_rd_arbiter
// Shares one AXI4 read interface (AR + R) between NUM_M requesters. AR requests
// are granted round-robin, and the granted index is prepended to ARID. R beats
// are routed back to the requester named by that index. Each requester may have
// at most MAX_OUTST bursts in flight.
//
// Ports:
//   aclk, areset        clock, asynchronous active-high reset
//   s_ar*               per-requester AR channels (packed, requester i at slice i)
//   m_ar*               shared AR channel, m_arid = {grant index, s_arid}
//   m_r*                shared R channel
//   s_r*                per-requester R valid/ready, payload broadcast
//   rid_err             sticky: R beat with an unknown index, or counter underflow
module ei_axi4_rd_arbiter #(
  parameter int unsigned NUM_M     = 2,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 4,
  localparam int unsigned IDX_W    = (NUM_M > 2) ? $clog2(NUM_M) : 1
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [NUM_M-1:0]        s_arvalid,
  output logic [NUM_M-1:0]        s_arready,
  input  logic [NUM_M*ADDR_W-1:0] s_araddr,
  input  logic [NUM_M*ID_W-1:0]   s_arid,
  input  logic [NUM_M*8-1:0]      s_arlen,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [ADDR_W-1:0]       m_araddr,
  output logic [ID_W+IDX_W-1:0]   m_arid,
  output logic [7:0]              m_arlen,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [ID_W+IDX_W-1:0]   m_rid,
  input  logic [DATA_W-1:0]       m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  output logic [NUM_M-1:0]        s_rvalid,
  input  logic [NUM_M-1:0]        s_rready,
  output logic [ID_W-1:0]         s_rid,
  output logic [DATA_W-1:0]       s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    rid_err
);

  // MAX_OUTST tops out at 15, so four bits always suffice.
  localparam int unsigned CNT_W = 4;

  typedef enum logic {StIdle = 1'b0, StGrant = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] outst_q [NUM_M];
  logic [CNT_W-1:0] outst_d [NUM_M];
  logic             rid_err_q, rid_err_d;

  logic [NUM_M-1:0] eligible;
  logic             found_hi, found_lo;
  logic [IDX_W-1:0] pick_hi, pick_lo;
  logic             ar_hs;
  logic [ID_W-1:0]  ar_id_sel;
  logic [IDX_W-1:0] r_idx;
  logic             r_idx_ok;
  logic             r_done;
  logic [NUM_M-1:0] cnt_inc, cnt_dec;

  // Eligibility: pending request and room for another burst.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_M; i++) begin
      eligible[i] = s_arvalid[i] && (32'(outst_q[i]) < MAX_OUTST);
    end
  end

  // Round-robin pick: pick_hi is the lowest eligible index at or above rr_ptr,
  // pick_lo the lowest eligible overall (used when the search wraps).
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        found_lo = 1'b1;
        pick_lo  = IDX_W'(i);
        if (32'(i) >= 32'(rr_ptr_q)) begin
          found_hi = 1'b1;
          pick_hi  = IDX_W'(i);
        end
      end
    end
  end

  // AR FSM next-state and outputs.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    m_arvalid = 1'b0;
    s_arready = '0;
    ar_hs     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found_lo) begin
          grant_d = found_hi ? pick_hi : pick_lo;
          state_d = StGrant;
        end
      end
      StGrant: begin
        m_arvalid = 1'b1;
        for (int i = 0; i < NUM_M; i++) begin
          s_arready[i] = m_arready && (grant_q == IDX_W'(i));
        end
        if (m_arready) begin
          ar_hs   = 1'b1;
          state_d = StIdle;
          if (32'(grant_q) == NUM_M - 1) rr_ptr_d = '0;
          else                           rr_ptr_d = grant_q + IDX_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // AR payload mux of the granted requester.
  always_comb begin
    m_araddr  = '0;
    m_arlen   = '0;
    ar_id_sel = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant_q == IDX_W'(i)) begin
        m_araddr  = s_araddr[i*ADDR_W +: ADDR_W];
        m_arlen   = s_arlen[i*8 +: 8];
        ar_id_sel = s_arid[i*ID_W +: ID_W];
      end
    end
  end

  assign m_arid = {grant_q, ar_id_sel};

  // R routing by the index in the upper ID bits. Unknown indices are
  // accepted (m_rready = 1) and dropped so the shared slave never stalls.
  assign r_idx    = m_rid[ID_W+IDX_W-1:ID_W];
  assign r_idx_ok = (32'(r_idx) < NUM_M);

  always_comb begin
    s_rvalid = '0;
    m_rready = 1'b1;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_idx == IDX_W'(i)) begin
        s_rvalid[i] = m_rvalid;
        m_rready    = s_rready[i];
      end
    end
  end

  assign r_done  = m_rvalid && m_rready && m_rlast;
  assign s_rid   = m_rid[ID_W-1:0];
  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;
  assign s_rlast = m_rlast;

  // Outstanding counters; a simultaneous increment and decrement cancel.
  always_comb begin
    rid_err_d = rid_err_q;
    cnt_inc   = '0;
    cnt_dec   = '0;
    if (m_rvalid && !r_idx_ok) rid_err_d = 1'b1;
    for (int i = 0; i < NUM_M; i++) begin
      outst_d[i] = outst_q[i];
      cnt_inc[i] = ar_hs && (grant_q == IDX_W'(i));
      cnt_dec[i] = r_done && (r_idx == IDX_W'(i));
      if (cnt_inc[i] && !cnt_dec[i]) begin
        if (outst_q[i] != '1) outst_d[i] = outst_q[i] + CNT_W'(1);
      end else if (cnt_dec[i] && !cnt_inc[i]) begin
        // A last beat with nothing outstanding is a protocol error.
        if (outst_q[i] == '0) rid_err_d  = 1'b1;
        else                  outst_d[i] = outst_q[i] - CNT_W'(1);
      end
    end
  end

  assign rid_err = rid_err_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      rid_err_q <= 1'b0;
      for (int i = 0; i < NUM_M; i++) outst_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      rid_err_q <= rid_err_d;
      for (int i = 0; i < NUM_M; i++) outst_q[i] <= outst_d[i];
    end
  end

endmodule

// File: tb/tb_ei_axi4_rd_arbiter.sv
// Scoreboard bench for ei_axi4_rd_arbiter. A 2-requester instance (MAX_OUTST=2)
// covers AR arbitration, limits, backpressure and reset; a 3-requester instance
// covers R routing with an out-of-range index.
module tb_ei_axi4_rd_arbiter;

  logic        aclk = 1'b0;
  logic        areset;
  logic [1:0]  s_arvalid, s_arready;
  logic [63:0] s_araddr;
  logic [7:0]  s_arid;
  logic [15:0] s_arlen;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [4:0]  m_arid;
  logic [7:0]  m_arlen;
  logic        m_rvalid, m_rready;
  logic [4:0]  m_rid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic [1:0]  s_rvalid, s_rready;
  logic [3:0]  s_rid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast, rid_err;

  logic [2:0]  t_s_arvalid, t_s_arready;
  logic [95:0] t_s_araddr;
  logic [11:0] t_s_arid;
  logic [23:0] t_s_arlen;
  logic        t_m_arvalid, t_m_arready;
  logic [31:0] t_m_araddr;
  logic [5:0]  t_m_arid;
  logic [7:0]  t_m_arlen;
  logic        t_m_rvalid, t_m_rready;
  logic [5:0]  t_m_rid;
  logic [31:0] t_m_rdata;
  logic [1:0]  t_m_rresp;
  logic        t_m_rlast;
  logic [2:0]  t_s_rvalid, t_s_rready;
  logic [3:0]  t_s_rid;
  logic [31:0] t_s_rdata;
  logic [1:0]  t_s_rresp;
  logic        t_s_rlast, t_rid_err;

  ei_axi4_rd_arbiter #(.NUM_M(2), .ID_W(4), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(2)) dut (
    .aclk(aclk), .areset(areset),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arid(m_arid), .m_arlen(m_arlen), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .rid_err(rid_err)
  );

  ei_axi4_rd_arbiter #(.NUM_M(3), .ID_W(4), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4)) dut3 (
    .aclk(aclk), .areset(areset),
    .s_arvalid(t_s_arvalid), .s_arready(t_s_arready), .s_araddr(t_s_araddr),
    .s_arid(t_s_arid), .s_arlen(t_s_arlen), .m_arvalid(t_m_arvalid),
    .m_arready(t_m_arready), .m_araddr(t_m_araddr), .m_arid(t_m_arid), .m_arlen(t_m_arlen),
    .m_rvalid(t_m_rvalid), .m_rready(t_m_rready), .m_rid(t_m_rid), .m_rdata(t_m_rdata),
    .m_rresp(t_m_rresp), .m_rlast(t_m_rlast), .s_rvalid(t_s_rvalid), .s_rready(t_s_rready),
    .s_rid(t_s_rid), .s_rdata(t_s_rdata), .s_rresp(t_s_rresp), .s_rlast(t_s_rlast),
    .rid_err(t_rid_err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
  } req_t;

  typedef struct {
    logic [4:0]  arid;
    logic [31:0] addr;
    logic [7:0]  len;
    int          cyc;   // expected handshake cycle, -1 = don't care
  } exp_ar_t;

  typedef struct {
    logic [1:0]  svalid;
    logic [31:0] data;
    logic [3:0]  rid;
    logic [1:0]  resp;
    logic        last;
  } exp_r_t;

  req_t    q0[$];
  req_t    q1[$];
  exp_ar_t exp_ar[$];
  exp_r_t  exp_r[$];
  int      checks   = 0;
  int      failures = 0;
  int      cyc      = 0;
  logic    hs0      = 1'b0;
  logic    hs1      = 1'b0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requesters must hold s_arvalid until accepted.
  a_hold0: assert property (@(posedge aclk) disable iff (areset)
    (s_arvalid[0] && !s_arready[0]) |=> s_arvalid[0])
    else $error("FAIL arvalid_hold0");
  a_hold1: assert property (@(posedge aclk) disable iff (areset)
    (s_arvalid[1] && !s_arready[1]) |=> s_arvalid[1])
    else $error("FAIL arvalid_hold1");

  // Requester drivers: present the head of each queue, pop on handshake.
  initial begin
    s_arvalid = '0;
    s_araddr  = '0;
    s_arid    = '0;
    s_arlen   = '0;
    forever begin
      @(posedge aclk);
      #1;
      if (hs0 && q0.size() > 0) q0.delete(0);
      if (hs1 && q1.size() > 0) q1.delete(0);
      if (q0.size() > 0) begin
        s_arvalid[0] = 1'b1;
        s_araddr[31:0] = q0[0].addr;
        s_arid[3:0] = q0[0].id;
        s_arlen[7:0] = q0[0].len;
      end else s_arvalid[0] = 1'b0;
      if (q1.size() > 0) begin
        s_arvalid[1] = 1'b1;
        s_araddr[63:32] = q1[0].addr;
        s_arid[7:4] = q1[0].id;
        s_arlen[15:8] = q1[0].len;
      end else s_arvalid[1] = 1'b0;
    end
  end

  // Monitor: compares every AR and R handshake against the scoreboard.
  initial begin : monitor
    exp_ar_t ea;
    exp_r_t  er;
    forever begin
      @(negedge aclk);
      hs0 = !areset && s_arvalid[0] && s_arready[0];
      hs1 = !areset && s_arvalid[1] && s_arready[1];
      if (!areset) begin
        if (m_arvalid && m_arready) begin
          if (exp_ar.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL ar_unexpected: got arid 0x%0h expected no handshake", m_arid);
          end else begin
            ea = exp_ar.pop_front();
            chk("ar_id", 64'(m_arid), 64'(ea.arid));
            chk("ar_addr", 64'(m_araddr), 64'(ea.addr));
            chk("ar_len", 64'(m_arlen), 64'(ea.len));
            chk("ar_sready", 64'(s_arready), 64'(2'b01 << ea.arid[4]));
            if (ea.cyc >= 0) chk("ar_cycle", 64'(cyc), 64'(ea.cyc));
          end
        end
        if (!m_arvalid) chk("ar_idle_sready", 64'(s_arready), 64'd0);
        if (m_rvalid && m_rready) begin
          if (exp_r.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL r_unexpected: got rid 0x%0h expected no beat", m_rid);
          end else begin
            er = exp_r.pop_front();
            chk("r_svalid", 64'(s_rvalid), 64'(er.svalid));
            chk("r_data", 64'(s_rdata), 64'(er.data));
            chk("r_id", 64'(s_rid), 64'(er.rid));
            chk("r_resp", 64'(s_rresp), 64'(er.resp));
            chk("r_last", 64'(s_rlast), 64'(er.last));
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge aclk);
    #1;
    areset = 1'b1;
    q0.delete();
    q1.delete();
    exp_ar.delete();
    exp_r.delete();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  task automatic wait_ar_drain(input string name);
    for (int n = 0; n < 40 && exp_ar.size() != 0; n++) @(posedge aclk);
    chk(name, 64'(exp_ar.size()), 64'd0);
  endtask

  task automatic wait_arvalid(input string name);
    logic seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge aclk);
      seen = m_arvalid;
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  task automatic send_r(input logic [4:0] rid, input logic [31:0] data,
                        input logic [1:0] resp, input logic last);
    logic got = 1'b0;
    @(posedge aclk);
    #1;
    m_rvalid = 1'b1;
    m_rid    = rid;
    m_rdata  = data;
    m_rresp  = resp;
    m_rlast  = last;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge aclk);
      got = m_rready;
    end
    chk("r_handshake", 64'(got), 64'd1);
    @(posedge aclk);
    #1;
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    areset      = 1'b1;
    m_arready   = 1'b0;
    m_rvalid    = 1'b0;
    m_rid       = '0;
    m_rdata     = '0;
    m_rresp     = '0;
    m_rlast     = 1'b0;
    s_rready    = 2'b11;
    t_s_arvalid = '0;
    t_s_araddr  = '0;
    t_s_arid    = '0;
    t_s_arlen   = '0;
    t_m_arready = 1'b0;
    t_m_rvalid  = 1'b0;
    t_m_rid     = '0;
    t_m_rdata   = '0;
    t_m_rresp   = '0;
    t_m_rlast   = 1'b0;
    t_s_rready  = '0;

    // Reset state.
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_sready", 64'(s_arready), 64'd0);
    chk("rst_rid_err", 64'(rid_err), 64'd0);
    chk("rst3_arvalid", 64'(t_m_arvalid), 64'd0);
    chk("rst3_rid_err", 64'(t_rid_err), 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // Single request: 1-cycle AR latency, R beat routed to requester 0.
    @(negedge aclk);
    m_arready = 1'b1;
    base = cyc;
    q0.push_back('{32'h0000_1000, 4'h3, 8'h00});
    exp_ar.push_back('{5'h03, 32'h0000_1000, 8'h00, base + 2});
    wait_ar_drain("single_ar_drain");
    @(negedge aclk);
    chk("single_bubble", 64'(m_arvalid), 64'd0);
    exp_r.push_back('{2'b01, 32'hCAFE_0001, 4'h3, 2'b00, 1'b1});
    send_r(5'h03, 32'hCAFE_0001, 2'b00, 1'b1);
    @(negedge aclk);
    chk("single_no_err", 64'(rid_err), 64'd0);
    // Counter is back at 0, so another last beat underflows and flags an error.
    exp_r.push_back('{2'b01, 32'hDEAD_0002, 4'h3, 2'b10, 1'b1});
    send_r(5'h03, 32'hDEAD_0002, 2'b10, 1'b1);
    @(negedge aclk);
    chk("underflow_err", 64'(rid_err), 64'd1);

    // Round-robin with one idle bubble between handshakes.
    do_reset();
    @(negedge aclk);
    m_arready = 1'b1;
    base = cyc;
    q0.push_back('{32'h0000_A000, 4'h1, 8'h01});
    q0.push_back('{32'h0000_A100, 4'h2, 8'h02});
    q1.push_back('{32'h0000_B000, 4'h9, 8'h03});
    q1.push_back('{32'h0000_B100, 4'hA, 8'h04});
    exp_ar.push_back('{5'h01, 32'h0000_A000, 8'h01, base + 2});
    exp_ar.push_back('{5'h19, 32'h0000_B000, 8'h03, base + 4});
    exp_ar.push_back('{5'h02, 32'h0000_A100, 8'h02, base + 6});
    exp_ar.push_back('{5'h1A, 32'h0000_B100, 8'h04, base + 8});
    wait_ar_drain("rr_drain");

    // Outstanding limit (MAX_OUTST=2).
    do_reset();
    @(negedge aclk);
    m_arready = 1'b1;
    base = cyc;
    q0.push_back('{32'h0000_3000, 4'h1, 8'h00});
    q0.push_back('{32'h0000_3004, 4'h2, 8'h00});
    q1.push_back('{32'h0000_4000, 4'h5, 8'h00});
    q1.push_back('{32'h0000_4004, 4'h6, 8'h00});
    q1.push_back('{32'h0000_4008, 4'h7, 8'h0F});
    exp_ar.push_back('{5'h01, 32'h0000_3000, 8'h00, base + 2});
    exp_ar.push_back('{5'h15, 32'h0000_4000, 8'h00, base + 4});
    exp_ar.push_back('{5'h02, 32'h0000_3004, 8'h00, base + 6});
    exp_ar.push_back('{5'h16, 32'h0000_4004, 8'h00, base + 8});
    wait_ar_drain("limit_drain");
    repeat (4) begin
      @(negedge aclk);
      chk("limit_stall_arvalid", 64'(m_arvalid), 64'd0);
      chk("limit_stall_sready", 64'(s_arready), 64'd0);
    end
    exp_ar.push_back('{5'h17, 32'h0000_4008, 8'h0F, -1});
    exp_r.push_back('{2'b10, 32'h0B0B_0001, 4'h6, 2'b00, 1'b1});
    send_r(5'h16, 32'h0B0B_0001, 2'b00, 1'b1);
    wait_ar_drain("limit_release");

    // AR backpressure: payload and grant hold while m_arready is low.
    do_reset();
    @(negedge aclk);
    m_arready = 1'b0;
    q1.push_back('{32'h2000_0040, 4'h7, 8'h03});
    wait_arvalid("bp_arvalid");
    q0.push_back('{32'h0000_5000, 4'h2, 8'h00});
    repeat (5) begin
      @(negedge aclk);
      chk("bp_arvalid_hold", 64'(m_arvalid), 64'd1);
      chk("bp_araddr", 64'(m_araddr), 64'h2000_0040);
      chk("bp_arid", 64'(m_arid), 64'h17);
      chk("bp_arlen", 64'(m_arlen), 64'h03);
      chk("bp_sready", 64'(s_arready), 64'd0);
    end
    exp_ar.push_back('{5'h17, 32'h2000_0040, 8'h03, -1});
    exp_ar.push_back('{5'h02, 32'h0000_5000, 8'h00, -1});
    @(posedge aclk);
    #1;
    m_arready = 1'b1;
    wait_ar_drain("bp_drain");

    // R backpressure from requester 1.
    @(posedge aclk);
    #1;
    s_rready = 2'b01;
    m_rvalid = 1'b1;
    m_rid    = 5'h17;
    m_rdata  = 32'h5555_AAAA;
    m_rresp  = 2'b01;
    m_rlast  = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      chk("rbp_mready", 64'(m_rready), 64'd0);
      chk("rbp_svalid", 64'(s_rvalid), 64'h2);
    end
    exp_r.push_back('{2'b10, 32'h5555_AAAA, 4'h7, 2'b01, 1'b0});
    @(posedge aclk);
    #1;
    s_rready = 2'b11;
    @(negedge aclk);
    chk("rbp_mready_up", 64'(m_rready), 64'd1);
    @(posedge aclk);
    #1;
    m_rvalid = 1'b0;
    @(negedge aclk);
    chk("rbp_drain", 64'(exp_r.size()), 64'd0);

    // NUM_M=3: valid index 2 routes; index 3 is dropped and flags rid_err.
    @(posedge aclk);
    #1;
    t_m_rvalid = 1'b1;
    t_m_rid    = {2'd2, 4'h9};
    t_m_rlast  = 1'b0;
    t_s_rready = 3'b100;
    @(negedge aclk);
    chk("n3_idx2_svalid", 64'(t_s_rvalid), 64'h4);
    chk("n3_idx2_mready", 64'(t_m_rready), 64'd1);
    @(posedge aclk);
    #1;
    t_s_rready = 3'b000;
    @(negedge aclk);
    chk("n3_idx2_stall", 64'(t_m_rready), 64'd0);
    chk("n3_no_err", 64'(t_rid_err), 64'd0);
    @(posedge aclk);
    #1;
    t_m_rid   = {2'd3, 4'h5};
    t_m_rlast = 1'b1;
    @(negedge aclk);
    chk("n3_bad_svalid", 64'(t_s_rvalid), 64'd0);
    chk("n3_bad_mready", 64'(t_m_rready), 64'd1);
    @(posedge aclk);
    #1;
    t_m_rvalid = 1'b0;
    t_m_rlast  = 1'b0;
    @(negedge aclk);
    chk("n3_err_set", 64'(t_rid_err), 64'd1);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("n3_err_sticky", 64'(t_rid_err), 64'd1);

    // Reset in GRANT with outst[0]=2 and rr_ptr=1.
    do_reset();
    @(negedge aclk);
    m_arready = 1'b1;
    q0.push_back('{32'h0000_6000, 4'h1, 8'h00});
    q0.push_back('{32'h0000_6004, 4'h2, 8'h00});
    exp_ar.push_back('{5'h01, 32'h0000_6000, 8'h00, -1});
    exp_ar.push_back('{5'h02, 32'h0000_6004, 8'h00, -1});
    wait_ar_drain("mid_pre_drain");
    @(negedge aclk);
    m_arready = 1'b0;
    q1.push_back('{32'h0000_7000, 4'h3, 8'h00});
    wait_arvalid("mid_grant");
    @(posedge aclk);
    #3;
    areset = 1'b1;
    #1;
    chk("mid_arvalid_async", 64'(m_arvalid), 64'd0);
    chk("mid_sready_async", 64'(s_arready), 64'd0);
    q0.delete();
    q1.delete();
    exp_ar.delete();
    exp_r.delete();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("mid_post_arvalid", 64'(m_arvalid), 64'd0);
    chk("mid_post_err", 64'(rid_err), 64'd0);
    // Stale beat for requester 0 finds a cleared counter.
    exp_r.push_back('{2'b01, 32'h0000_7777, 4'h1, 2'b00, 1'b1});
    send_r(5'h01, 32'h0000_7777, 2'b00, 1'b1);
    @(negedge aclk);
    chk("mid_outst_cleared", 64'(rid_err), 64'd1);
    // rr_ptr cleared: requester 0 wins over requester 1.
    m_arready = 1'b1;
    base = cyc;
    q1.push_back('{32'h0000_8000, 4'h4, 8'h00});
    q0.push_back('{32'h0000_9000, 4'h5, 8'h00});
    exp_ar.push_back('{5'h05, 32'h0000_9000, 8'h00, base + 2});
    exp_ar.push_back('{5'h14, 32'h0000_8000, 8'h00, base + 4});
    wait_ar_drain("mid_rr_drain");

    repeat (3) @(posedge aclk);
    chk("final_r_drain", 64'(exp_r.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
